dma_mc: RTL and testbench

Parametrised multi-channel DMA controller, the successor to the single-channel DMA. It transfers word blocks between memory and IO, supporting memory-to-memory, IO-to-memory and memory-to-IO on NCH independent channels. Each channel has a transfer count, single or burst mode, and per-side fixed/increment addressing. It sits between the processor and the shared memory/IO bus. It arbitrates round-robin among channels, and the processor request takes priority at word boundaries.

---
 rtl/dma_mc_if.sv | 16 +
 rtl/dma_mc.sv | 182 ++++++++++++++++++
 tb/tb_dma_mc.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_mc_if.sv
// Shared memory/IO bus between the DMA controller (master) and the memory/IO side (slave).
// Bus cycle semantics: a cycle is active while mreq_ is low; mrw_=1 is a read whose data
// appears on mrdata during the following cycle, mrw_=0 writes mwdata to maddr.
interface dma_mc_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] maddr;
    logic [DATA_WIDTH-1:0] mwdata;
    logic [DATA_WIDTH-1:0] mrdata;
    logic                  mrw_;
    logic                  mreq_;

    modport master (output maddr, output mwdata, output mrw_, output mreq_, input mrdata);
    modport slave  (input maddr, input mwdata, input mrw_, input mreq_, output mrdata);
endinterface

// File: rtl/dma_mc.sv
// Multi-channel DMA controller: NCH descriptor slots, round-robin word arbitration,
// processor bus request honoured only between words. Each word is RD -> CAP -> WR.
module dma_mc #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int NCH        = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic                      breq_,
    output logic                      bgrt_,
    input  logic [NCH-1:0]            dreq_,
    input  logic [NCH*ADDR_WIDTH-1:0] dsaddr,
    input  logic [NCH*ADDR_WIDTH-1:0] ddaddr,
    input  logic [NCH*CNT_WIDTH-1:0]  dcount,
    input  logic [NCH*3-1:0]          dmode,
    output logic [NCH-1:0]            eop_,
    output logic [NCH-1:0]            busy,
    dma_mc_if.master                  bus,
    output logic [1:0]                dbg_state
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_CAP = 2'd2, S_WR = 2'd3} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic [CW-1:0]         ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  bgrt_q, bgrt_d;
    logic [ADDR_WIDTH-1:0] src_q [NCH];
    logic [ADDR_WIDTH-1:0] src_d [NCH];
    logic [ADDR_WIDTH-1:0] dst_q [NCH];
    logic [ADDR_WIDTH-1:0] dst_d [NCH];
    logic [CNT_WIDTH-1:0]  cnt_q [NCH];
    logic [CNT_WIDTH-1:0]  cnt_d [NCH];
    logic [2:0]            mode_q [NCH];
    logic [2:0]            mode_d [NCH];
    logic [NCH-1:0]        busy_q, busy_d;
    logic [NCH-1:0]        eop_q, eop_d;

    logic                  found;
    logic [CW-1:0]         pick;
    logic [CW:0]           arb_sum;

    assign bgrt_     = bgrt_q;
    assign eop_      = eop_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

    // Round-robin search: first busy channel at or after the pointer, wrapping.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        arb_sum = '0;
        for (int k = 0; k < NCH; k++) begin
            arb_sum = {1'b0, ptr_q} + (CW+1)'(k);
            if (arb_sum >= (CW+1)'(NCH)) arb_sum = arb_sum - (CW+1)'(NCH);
            if (!found && busy_q[arb_sum[CW-1:0]]) begin
                found = 1'b1;
                pick  = arb_sum[CW-1:0];
            end
        end
    end

    // Descriptor loading plus FSM next-state; completion and load never collide
    // because a channel in WR is still busy and so ignores its dreq_.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        bgrt_d  = 1'b1;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        eop_d   = '1;

        for (int i = 0; i < NCH; i++) begin
            if (!dreq_[i] && !busy_q[i]) begin
                if (dcount[i*CNT_WIDTH +: CNT_WIDTH] == '0) begin
                    eop_d[i] = 1'b0;
                end else begin
                    busy_d[i] = 1'b1;
                    src_d[i]  = dsaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    dst_d[i]  = ddaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    cnt_d[i]  = dcount[i*CNT_WIDTH +: CNT_WIDTH];
                    mode_d[i] = dmode[i*3 +: 3];
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (!breq_) begin
                    bgrt_d = 1'b0;
                end else if (found) begin
                    ch_d    = pick;
                    ptr_d   = (pick == CW'(NCH-1)) ? '0 : pick + 1'b1;
                    state_d = S_RD;
                end
            end
            S_RD:  state_d = S_CAP;
            S_CAP: begin
                data_d  = bus.mrdata;
                state_d = S_WR;
            end
            S_WR: begin
                cnt_d[ch_q] = cnt_q[ch_q] - 1'b1;
                if (!mode_q[ch_q][1]) src_d[ch_q] = src_q[ch_q] + 1'b1;
                if (!mode_q[ch_q][2]) dst_d[ch_q] = dst_q[ch_q] + 1'b1;
                if (cnt_q[ch_q] == CNT_WIDTH'(1)) begin
                    eop_d[ch_q]  = 1'b0;
                    busy_d[ch_q] = 1'b0;
                    state_d      = S_IDLE;
                end else if (!mode_q[ch_q][0] || !breq_) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs decoded from the current state; idle/CAP leave the bus at rest values.
    always_comb begin
        bus.mreq_  = 1'b1;
        bus.mrw_   = 1'b1;
        bus.maddr  = '0;
        bus.mwdata = '0;
        case (state_q)
            S_RD: begin
                bus.mreq_ = 1'b0;
                bus.maddr = src_q[ch_q];
            end
            S_WR: begin
                bus.mreq_  = 1'b0;
                bus.mrw_   = 1'b0;
                bus.maddr  = dst_q[ch_q];
                bus.mwdata = data_q;
            end
            default: ;
        endcase
    end

    // State registers; reset drops descriptors and aborts any word without an eop_.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            bgrt_q  <= 1'b1;
            busy_q  <= '0;
            eop_q   <= '1;
            for (int i = 0; i < NCH; i++) begin
                src_q[i]  <= '0;
                dst_q[i]  <= '0;
                cnt_q[i]  <= '0;
                mode_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            bgrt_q  <= bgrt_d;
            busy_q  <= busy_d;
            eop_q   <= eop_d;
            for (int i = 0; i < NCH; i++) begin
                src_q[i]  <= src_d[i];
                dst_q[i]  <= dst_d[i];
                cnt_q[i]  <= cnt_d[i];
                mode_q[i] <= mode_d[i];
            end
        end
    end
endmodule

// File: tb/tb_dma_mc.sv
// Bench for dma_mc: memory model on the bus, bus/eop_/bgrt_ monitors, and a word-level
// reference model that predicts every bus cycle (time, direction, address, data).
module tb_dma_mc;
    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int BW  = 35;
    localparam int EW  = 20;

    logic                clk = 1'b0;
    logic                reset_;
    logic                breq_;
    logic                bgrt_;
    logic [NCH-1:0]      dreq_;
    logic [NCH*AW-1:0]   dsaddr;
    logic [NCH*AW-1:0]   ddaddr;
    logic [NCH*CW-1:0]   dcount;
    logic [NCH*3-1:0]    dmode;
    logic [NCH-1:0]      eop_;
    logic [NCH-1:0]      busy;
    logic [1:0]          dbg_state;

    dma_mc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dma_mc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NCH(NCH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_(reset_), .breq_(breq_), .bgrt_(bgrt_), .dreq_(dreq_),
        .dsaddr(dsaddr), .ddaddr(ddaddr), .dcount(dcount), .dmode(dmode),
        .eop_(eop_), .busy(busy), .bus(bus), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory/IO model: read data valid the cycle after the read strobe
    logic [7:0] mem [1024];
    logic [7:0] ref_mem [1024];
    logic [7:0] rd_q = 8'h00;
    always @(posedge clk) begin
        if (!bus.mreq_ && bus.mrw_) rd_q <= mem[bus.maddr];
        if (!bus.mreq_ && !bus.mrw_) mem[bus.maddr] <= bus.mwdata;
    end
    assign bus.mrdata = rd_q;

    // monitors
    logic [BW-1:0] bus_q[$];
    logic [BW-1:0] exp_q[$];
    logic [EW-1:0] eop_q[$];
    logic [EW-1:0] eexp_q[$];
    int            bg_q[$];
    int            bg_viol = 0;
    always @(negedge clk) begin
        if (reset_ === 1'b1) begin
            if (bus.mreq_ === 1'b0)
                bus_q.push_back({cyc[15:0], bus.mrw_, bus.maddr, bus.mrw_ ? 8'h00 : bus.mwdata});
            for (int i = 0; i < NCH; i++)
                if (eop_[i] === 1'b0) eop_q.push_back({cyc[15:0], 4'(i)});
            if (bgrt_ === 1'b0) begin
                bg_q.push_back(cyc);
                if (dbg_state !== 2'd0) bg_viol++;
            end
        end
    end

    // scoreboard counters
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model state
    logic [AW-1:0] m_ds [NCH];
    logic [AW-1:0] m_dd [NCH];
    int            m_cnt [NCH];
    logic [2:0]    m_mode [NCH];
    bit            m_load [NCH];
    int            m_ptr = 0;

    // Word-level model: round-robin among loaded channels, 3 cycles per word, one IDLE
    // cycle between words unless a burst continues; hold_word pauses after that word.
    task automatic model_run(input int c, input int hold_word, input int hold_until);
        int t, trd, pick, w, idx;
        bit h;
        logic [7:0] dt;
        t = c + 1;
        w = 0;
        for (int i = 0; i < NCH; i++)
            if (m_load[i] && m_cnt[i] == 0) begin
                eexp_q.push_back({16'(c + 1), 4'(i)});
                m_load[i] = 1'b0;
            end
        forever begin
            pick = -1;
            for (int k = 0; k < NCH; k++) begin
                idx = (m_ptr + k) % NCH;
                if (pick < 0 && m_load[idx]) pick = idx;
            end
            if (pick < 0) break;
            m_ptr = (pick + 1) % NCH;
            trd = t + 1;
            forever begin
                exp_q.push_back({16'(trd), 1'b1, m_ds[pick], 8'h00});
                dt = ref_mem[m_ds[pick]];
                ref_mem[m_dd[pick]] = dt;
                exp_q.push_back({16'(trd + 2), 1'b0, m_dd[pick], dt});
                if (!m_mode[pick][1]) m_ds[pick] = m_ds[pick] + 1'b1;
                if (!m_mode[pick][2]) m_dd[pick] = m_dd[pick] + 1'b1;
                m_cnt[pick]--;
                h = (w == hold_word);
                w++;
                if (m_cnt[pick] == 0) begin
                    eexp_q.push_back({16'(trd + 3), 4'(pick)});
                    m_load[pick] = 1'b0;
                    t = h ? hold_until : trd + 3;
                    break;
                end else if (m_mode[pick][0] && !h) begin
                    trd += 3;
                end else begin
                    t = h ? hold_until : trd + 3;
                    break;
                end
            end
        end
    endtask

    // driver tasks
    task automatic drive_desc(input int ch, input logic [AW-1:0] ds, input logic [AW-1:0] dd,
                              input logic [CW-1:0] cnt, input logic [2:0] mode);
        dsaddr[ch*AW +: AW] = ds;
        ddaddr[ch*AW +: AW] = dd;
        dcount[ch*CW +: CW] = cnt;
        dmode[ch*3 +: 3]    = mode;
    endtask

    task automatic set_desc(input int ch, input logic [AW-1:0] ds, input logic [AW-1:0] dd,
                            input logic [CW-1:0] cnt, input logic [2:0] mode);
        drive_desc(ch, ds, dd, cnt, mode);
        m_ds[ch]   = ds;
        m_dd[ch]   = dd;
        m_cnt[ch]  = int'(cnt);
        m_mode[ch] = mode;
        m_load[ch] = 1'b1;
    endtask

    task automatic pulse(input logic [NCH-1:0] mask, output int c);
        @(posedge clk); #1;
        dreq_ = ~mask;
        c = cyc;
        @(posedge clk); #1;
        dreq_ = '1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (busy === '0 && dbg_state === 2'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " done"}, 64'(ok), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare(input string tag);
        check({tag, " bus count"}, 64'(bus_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < bus_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s bus[%0d]", tag, i), 64'(bus_q[i]), 64'(exp_q[i]));
        check({tag, " eop count"}, 64'(eop_q.size()), 64'(eexp_q.size()));
        for (int i = 0; i < eop_q.size() && i < eexp_q.size(); i++)
            check($sformatf("%s eop[%0d]", tag, i), 64'(eop_q[i]), 64'(eexp_q[i]));
        bus_q.delete(); exp_q.delete(); eop_q.delete(); eexp_q.delete(); bg_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_ = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_ = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < NCH; i++) m_load[i] = 1'b0;
        bus_q.delete(); eop_q.delete(); bg_q.delete();
    endtask

    // watchdog
    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // directed + randomized sequence
    initial begin
        int c, c2;
        logic [NCH-1:0] mask;
        reset_ = 1'b0;
        breq_  = 1'b1;
        dreq_  = '1;
        dsaddr = '0; ddaddr = '0; dcount = '0; dmode = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < NCH; i++) m_load[i] = 1'b0;

        // reset values
        #12;
        check("rst mreq_", 64'(bus.mreq_), 64'd1);
        check("rst mrw_", 64'(bus.mrw_), 64'd1);
        check("rst maddr", 64'(bus.maddr), 64'd0);
        check("rst mwdata", 64'(bus.mwdata), 64'd0);
        check("rst bgrt_", 64'(bgrt_), 64'd1);
        check("rst eop_", 64'(eop_), 64'(2'b11));
        check("rst busy", 64'(busy), 64'd0);
        check("rst state", 64'(dbg_state), 64'd0);
        @(posedge clk); #1 reset_ = 1'b1;

        // M2M burst
        mem[10'h150] = 8'd99; mem[10'h151] = 8'd90; mem[10'h152] = 8'd50;
        ref_mem[10'h150] = 8'd99; ref_mem[10'h151] = 8'd90; ref_mem[10'h152] = 8'd50;
        set_desc(0, 10'h150, 10'h160, 8'd3, 3'b001);
        pulse(2'b01, c);
        model_run(c, -1, 0);
        wait_done("m2m");
        compare("m2m");
        check("m2m mem160", 64'(mem[10'h160]), 64'd99);
        check("m2m mem161", 64'(mem[10'h161]), 64'd90);
        check("m2m mem162", 64'(mem[10'h162]), 64'd50);

        // IO2M burst, fixed source
        set_desc(0, 10'h200, 10'h170, 8'd2, 3'b011);
        pulse(2'b01, c);
        model_run(c, -1, 0);
        wait_done("io2m");
        compare("io2m");

        // M2IO on two channels, single mode, loaded together from pointer 0
        do_reset();
        set_desc(0, 10'h170, 10'h020, 8'd2, 3'b100);
        set_desc(1, 10'h180, 10'h021, 8'd2, 3'b100);
        pulse(2'b11, c);
        model_run(c, -1, 0);
        wait_done("m2io");
        check("m2io first eop ch", 64'(eop_q.size() > 0 ? eop_q[0][3:0] : 4'hF), 64'd0);
        compare("m2io");

        // processor preemption mid-word of a count=4 burst
        set_desc(0, 10'h300, 10'h310, 8'd4, 3'b001);
        pulse(2'b01, c);
        model_run(c, 0, c + 10);
        wait_cyc(c + 3);
        breq_ = 1'b0;
        wait_cyc(c + 10);
        breq_ = 1'b1;
        wait_done("preempt");
        check("preempt bgrt low cycles", 64'(bg_q.size()), 64'd5);
        check("preempt bgrt first", 64'(bg_q.size() > 0 ? bg_q[0] : -1), 64'(c + 6));
        compare("preempt");

        // count=0: eop_ pulse only
        set_desc(1, 10'h010, 10'h011, 8'd0, 3'b001);
        pulse(2'b10, c);
        check("cnt0 busy", 64'(busy[1]), 64'd0);
        model_run(c, -1, 0);
        wait_done("cnt0");
        compare("cnt0");

        // source address wrap at top of range
        set_desc(1, 10'h3FF, 10'h050, 8'd2, 3'b001);
        pulse(2'b10, c);
        model_run(c, -1, 0);
        wait_done("wrap");
        compare("wrap");

        // dreq_ while busy is ignored
        set_desc(0, 10'h080, 10'h0A0, 8'd3, 3'b001);
        pulse(2'b01, c);
        model_run(c, -1, 0);
        wait_cyc(c + 4);
        drive_desc(0, 10'h111, 10'h222, 8'd5, 3'b000);
        pulse(2'b01, c2);
        wait_done("busyreq");
        compare("busyreq");

        // randomized jobs on one or both channels
        for (int r = 0; r < 6; r++) begin
            mask = NCH'($urandom_range(1, 3));
            for (int ch = 0; ch < NCH; ch++)
                if (mask[ch])
                    set_desc(ch, AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)),
                             CW'($urandom_range(0, 5)), 3'($urandom_range(0, 7)));
            pulse(mask, c);
            model_run(c, -1, 0);
            wait_done($sformatf("rand%0d", r));
            compare($sformatf("rand%0d", r));
        end

        // reset asserted during the first WR of a burst
        set_desc(0, 10'h0C0, 10'h0D0, 8'd3, 3'b001);
        pulse(2'b01, c);
        for (int n = 0; n < 20 && dbg_state !== 2'd3; n++) @(negedge clk);
        check("rstwr reached WR", 64'(dbg_state), 64'd3);
        reset_ = 1'b0;
        #1;
        check("rstwr mreq_", 64'(bus.mreq_), 64'd1);
        check("rstwr mrw_", 64'(bus.mrw_), 64'd1);
        check("rstwr maddr", 64'(bus.maddr), 64'd0);
        check("rstwr mwdata", 64'(bus.mwdata), 64'd0);
        check("rstwr busy", 64'(busy), 64'd0);
        check("rstwr eop_", 64'(eop_), 64'(2'b11));
        check("rstwr state", 64'(dbg_state), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_ = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < NCH; i++) m_load[i] = 1'b0;
        bus_q.delete(); eop_q.delete(); bg_q.delete();
        repeat (10) @(negedge clk);
        compare("rstwr");

        // recovery after reset
        set_desc(1, 10'h0E0, 10'h0F0, 8'd2, 3'b001);
        pulse(2'b10, c);
        model_run(c, -1, 0);
        wait_done("recover");
        compare("recover");

        // final report
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
            check("memory image", 64'(bad), 64'd0);
        end
        check("bgrt_ outside IDLE", 64'(bg_viol), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
